// File: rtl/mdio_link_poller.sv
// mdio_link_poller: arbitrates one mdio_master between host commands and a
// periodic PHY status poll, and publishes the polled link state and speed.
module mdio_link_poller #(
  parameter logic [23:0] POLL_INTERVAL = 24'd1250000,
  parameter logic [4:0]  POLL_REG      = 5'h11,
  parameter int          LINK_BIT      = 10,
  parameter int          SPEED_LSB     = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [4:0]  poll_phy_addr,
  input  logic [4:0]  s_cmd_phy_addr,
  input  logic [4:0]  s_cmd_reg_addr,
  input  logic [15:0] s_cmd_data,
  input  logic [1:0]  s_cmd_opcode,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  output logic [15:0] s_data_out,
  output logic        s_data_out_valid,
  input  logic        s_data_out_ready,
  output logic [4:0]  m_cmd_phy_addr,
  output logic [4:0]  m_cmd_reg_addr,
  output logic [15:0] m_cmd_data,
  output logic [1:0]  m_cmd_opcode,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  input  logic [15:0] m_data_out,
  input  logic        m_data_out_valid,
  output logic        m_data_out_ready,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        status_valid,
  output logic        status_change,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam logic [23:0] TIMER_MAX = POLL_INTERVAL - 24'd1;

  state_t      state_q, state_d;
  logic        src_poll_q;
  logic [23:0] timer_q;
  logic        poll_pending_q;
  logic        discard_q;
  logic        host_take, poll_take, poll_rd_done;
  logic        new_link;
  logic [1:0]  new_speed;

  assign m_cmd_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign new_link    = m_data_out[LINK_BIT];
  assign new_speed   = m_data_out[SPEED_LSB +: 2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, arbitration and read-data steering
  always_comb begin
    state_d          = state_q;
    host_take        = 1'b0;
    poll_take        = 1'b0;
    poll_rd_done     = 1'b0;
    s_cmd_ready      = 1'b0;
    s_data_out       = 16'h0;
    s_data_out_valid = 1'b0;
    m_data_out_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // stray read data outside a read is drained and dropped
        m_data_out_ready = m_data_out_valid;
        if (s_cmd_valid) begin
          s_cmd_ready = 1'b1;
          host_take   = 1'b1;
          state_d     = ISSUE;
        end else if (poll_pending_q) begin
          poll_take = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        m_data_out_ready = m_data_out_valid;
        if (m_cmd_ready) state_d = m_cmd_opcode[1] ? WAIT_RD : IDLE;
      end
      WAIT_RD: begin
        if (src_poll_q) begin
          m_data_out_ready = 1'b1;
          if (m_data_out_valid) begin
            poll_rd_done = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          s_data_out       = m_data_out;
          s_data_out_valid = m_data_out_valid;
          m_data_out_ready = s_data_out_ready;
          if (m_data_out_valid && s_data_out_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch toward mdio_master, held stable through ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cmd_phy_addr <= 5'h0;
      m_cmd_reg_addr <= 5'h0;
      m_cmd_data     <= 16'h0;
      m_cmd_opcode   <= 2'b00;
      src_poll_q     <= 1'b0;
    end else if (host_take) begin
      m_cmd_phy_addr <= s_cmd_phy_addr;
      m_cmd_reg_addr <= s_cmd_reg_addr;
      m_cmd_data     <= s_cmd_data;
      m_cmd_opcode   <= s_cmd_opcode;
      src_poll_q     <= 1'b0;
    end else if (poll_take) begin
      m_cmd_phy_addr <= poll_phy_addr;
      m_cmd_reg_addr <= POLL_REG;
      m_cmd_data     <= 16'h0;
      m_cmd_opcode   <= 2'b10;
      src_poll_q     <= 1'b1;
    end
  end

  // Poll timer and single-deep pending flag; an expiry wins over the take
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      timer_q        <= 24'h0;
      poll_pending_q <= 1'b0;
    end else begin
      if (poll_take) poll_pending_q <= 1'b0;
      if (timer_q == TIMER_MAX) begin
        timer_q        <= 24'h0;
        poll_pending_q <= 1'b1;
      end else begin
        timer_q <= timer_q + 24'd1;
      end
    end
  end

  // A poll in flight when enable drops must not publish its result
  always_ff @(posedge clk) begin
    if (rst)            discard_q <= 1'b0;
    else if (!enable)   discard_q <= 1'b1;
    else if (poll_take) discard_q <= 1'b0;
  end

  // Published link status; change pulse only once status is already valid
  always_ff @(posedge clk) begin
    if (rst) begin
      link_up       <= 1'b0;
      link_speed    <= 2'b00;
      status_valid  <= 1'b0;
      status_change <= 1'b0;
    end else begin
      status_change <= 1'b0;
      if (!enable) status_valid <= 1'b0;
      if (poll_rd_done && enable && !discard_q) begin
        link_up       <= new_link;
        link_speed    <= new_speed;
        status_valid  <= 1'b1;
        status_change <= status_valid &&
                         ((new_link != link_up) || (new_speed != link_speed));
      end
    end
  end

endmodule

// File: doc/mdio_link_poller.md
Name: mdio_link_poller

Overview:
- Sits between the AXI-lite MDIO register interface and one mdio_master instance; one poller per MDIO interface.
- Shares the mdio_master command/read-data channel between host requests and an autonomous status poll.
- The poll periodically reads a PHY status register and publishes link state and speed. A downstream link-speed sync controller consumes this status to force both PHYs to the same speed.

Parameters:
- POLL_INTERVAL, 24'd1250000, clock cycles between poll requests (10 ms at 125 MHz); must be ≥ 2.
- POLL_REG, 5'h11, PHY register address read by the poll.
- LINK_BIT, 10, bit index of link-up in the polled word.
- SPEED_LSB, 14, LSB of the 2-bit speed field in the polled word (bits SPEED_LSB+1:SPEED_LSB).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  poll enable
- poll_phy_addr  in  5  PHY address used for polls
- s_cmd_phy_addr  in  5  host command PHY address
- s_cmd_reg_addr  in  5  host command register address
- s_cmd_data  in  16  host write data
- s_cmd_opcode  in  2  host opcode (2'b01 write, 2'b10 read)
- s_cmd_valid  in  1  host command valid
- s_cmd_ready  out  1  host command accepted
- s_data_out  out  16  host read data
- s_data_out_valid  out  1  host read data valid
- s_data_out_ready  in  1  host read data ready
- m_cmd_phy_addr  out  5  to mdio_master
- m_cmd_reg_addr  out  5  to mdio_master
- m_cmd_data  out  16  to mdio_master
- m_cmd_opcode  out  2  to mdio_master
- m_cmd_valid  out  1  to mdio_master
- m_cmd_ready  in  1  from mdio_master
- m_data_out  in  16  read data from mdio_master
- m_data_out_valid  in  1  from mdio_master
- m_data_out_ready  out  1  to mdio_master
- link_up  out  1  last polled link bit
- link_speed  out  2  last polled speed field
- status_valid  out  1  high once any poll has completed since reset/enable rise
- status_change  out  1  one-cycle pulse when link_up or link_speed changes
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; poll timer is 0; poll_pending is 0.
- Poll timer:
  - Counts while enable=1.
  - At count POLL_INTERVAL-1: sets poll_pending and wraps to 0.
  - While enable=0: timer is held at 0, poll_pending is cleared, and status_valid is cleared.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If s_cmd_valid=1:
    - Assert s_cmd_ready combinationally.
    - Latch the host command into the m_cmd_* registers and set src=HOST.
    - Go to ISSUE.
  - Else if poll_pending=1:
    - Latch {poll_phy_addr, POLL_REG, 16'h0, 2'b10}, set src=POLL, clear poll_pending.
    - Go to ISSUE.
  - Host has priority when both are present in the same cycle; the poll stays pending.
- ISSUE:
  - m_cmd_valid=1 with the latched fields held stable.
  - On m_cmd_ready: go to WAIT_RD if the opcode is 2'b10 or 2'b11, else go to IDLE.
  - s_cmd_ready=0 in all non-IDLE states.
- WAIT_RD, src=HOST:
  - s_data_out = m_data_out; s_data_out_valid = m_data_out_valid; m_data_out_ready = s_data_out_ready.
  - Go to IDLE on the handshake.
- WAIT_RD, src=POLL:
  - m_data_out_ready=1.
  - On m_data_out_valid: register link_up and link_speed from the word and set status_valid.
  - Pulse status_change on the next cycle if either value differs from its previous value. No pulse on the first poll after status_valid was 0.
  - Go to IDLE.
- m_data_out_valid while in IDLE/ISSUE is unexpected: accept it (m_data_out_ready=1) and discard it.
- s_data_out_valid is 0 outside WAIT_RD with src=HOST.
- Latency:
  - Host command accepted in the same cycle as valid when IDLE.
  - m_cmd_valid rises the cycle after acceptance.
- enable deasserted mid-poll: the poll in flight completes and its result is discarded (status_valid stays 0).
- The timer keeps running during host transactions; at most one poll is pending, so further expiries while pending are absorbed.
- rst mid-operation: returns to IDLE next cycle and drops m_cmd_valid. The mdio_master shares rst and resets with it.

Test Plan:
- Reset, enable=1, POLL_INTERVAL=16, m_cmd_ready=1, mdio_master returns 16'h6400 → poll cmd {phy=poll_phy_addr, reg=0x11, op=2'b10} at cycle ~16; then link_up=1, link_speed=2'b01, status_valid=1, no status_change.
- Second poll returns 16'h8400 → link_speed=2'b10, status_change pulses exactly one cycle.
- Host write (op 2'b01, reg 0, data 16'h1140) in the same cycle poll_pending sets → host is issued first; poll is issued immediately after returning to IDLE; s_data_out_valid never asserts.
- Host read of reg 2, mdio_master returns 16'h0022, s_data_out_ready held low 5 cycles → s_data_out_valid stays high with 16'h0022 and m_data_out_ready=0 until s_data_out_ready=1; link_up is unchanged.
- enable dropped during poll WAIT_RD → read is completed and consumed; status_valid=0; no new poll while enable=0.
- Stray m_data_out_valid in IDLE → consumed, no s_data_out_valid, status unchanged.
